// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM signal bundle for the execute stage.
// slave: the execute stage itself; master: the upstream/downstream driver.
interface ex_stage_if #(parameter int XLEN = 32);
    logic [XLEN-1:0] id_ex_reg_op_a_i;
    logic [XLEN-1:0] id_ex_reg_op_b_i;
    logic [4:0]      id_ex_reg_ALUctrl_i;
    logic [4:0]      id_ex_reg_reg_waddr_i;
    logic            id_ex_reg_reg_we_i;
    logic [XLEN-1:0] ex_reg_wdata_o;
    logic [4:0]      ex_reg_waddr_o;
    logic            ex_reg_we_o;
    logic            ex_stall_o;

    modport slave (
        input  id_ex_reg_op_a_i, id_ex_reg_op_b_i, id_ex_reg_ALUctrl_i,
               id_ex_reg_reg_waddr_i, id_ex_reg_reg_we_i,
        output ex_reg_wdata_o, ex_reg_waddr_o, ex_reg_we_o, ex_stall_o
    );

    modport master (
        output id_ex_reg_op_a_i, id_ex_reg_op_b_i, id_ex_reg_ALUctrl_i,
               id_ex_reg_reg_waddr_i, id_ex_reg_reg_we_i,
        input  ex_reg_wdata_o, ex_reg_waddr_o, ex_reg_we_o, ex_stall_o
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus an iterative restoring divider
// that stalls the front of the pipe while it iterates.
module ex_stage #(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    ex_stage_if.slave  bus
);
    localparam int CNT_W = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    localparam logic [4:0] OP_NOP  = 5'd0,  OP_ADD  = 5'd1,  OP_SUB  = 5'd2,
                           OP_AND  = 5'd3,  OP_OR   = 5'd4,  OP_XOR  = 5'd5,
                           OP_SLL  = 5'd6,  OP_SRL  = 5'd7,  OP_SRA  = 5'd8,
                           OP_SLT  = 5'd9,  OP_SLTU = 5'd10, OP_DIV  = 5'd11,
                           OP_DIVU = 5'd12, OP_REM  = 5'd13, OP_REMU = 5'd14;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] quo, rem, dvs;
    logic            q_neg, r_neg, l_rem, l_we;
    logic [4:0]      l_waddr;

    logic [XLEN-1:0] a, b, alu_res, spec_res, a_mag, b_mag, q_fix, r_fix, div_res;
    logic [4:0]      op;
    logic            is_div, is_signed, is_rem, div_zero, div_ovf, special;
    logic            valid_op, we_eff, a_neg, b_neg, lt_s, lt_u;
    logic [XLEN:0]   rem_sh, diff;

    assign a  = bus.id_ex_reg_op_a_i;
    assign b  = bus.id_ex_reg_op_b_i;
    assign op = bus.id_ex_reg_ALUctrl_i;

    assign lt_s = $signed(a) < $signed(b);
    assign lt_u = a < b;

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = a << b[4:0];
            OP_SRL:  alu_res = a >> b[4:0];
            OP_SRA:  alu_res = $signed(a) >>> b[4:0];
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
            default: alu_res = '0;
        endcase
    end

    assign is_div    = (op >= OP_DIV) && (op <= OP_REMU);
    assign is_signed = (op == OP_DIV) || (op == OP_REM);
    assign is_rem    = (op == OP_REM) || (op == OP_REMU);
    assign div_zero  = (b == '0);
    assign div_ovf   = is_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign special   = div_zero || div_ovf;

    // Divide-by-zero and signed overflow resolve without iterating.
    assign spec_res = div_zero ? (is_rem ? a : '1)
                               : (is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}});

    assign valid_op = (op != OP_NOP) && (op <= OP_REMU);
    assign we_eff   = bus.id_ex_reg_reg_we_i && (bus.id_ex_reg_reg_waddr_i != 5'd0) && valid_op;

    assign a_neg = is_signed && a[XLEN-1];
    assign b_neg = is_signed && b[XLEN-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Restoring step: shift next dividend bit into the partial remainder, trial subtract.
    assign rem_sh = {rem, quo[XLEN-1]};
    assign diff   = rem_sh - {1'b0, dvs};

    assign q_fix   = q_neg ? -quo : quo;
    assign r_fix   = r_neg ? -rem : rem;
    assign div_res = l_rem ? r_fix : q_fix;

    assign bus.ex_stall_o = ((state == IDLE) && is_div && !special) || (state == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            cnt                <= '0;
            quo                <= '0;
            rem                <= '0;
            dvs                <= '0;
            q_neg              <= 1'b0;
            r_neg              <= 1'b0;
            l_rem              <= 1'b0;
            l_we               <= 1'b0;
            l_waddr            <= '0;
            bus.ex_reg_wdata_o <= '0;
            bus.ex_reg_waddr_o <= '0;
            bus.ex_reg_we_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_div && !special) begin
                        quo             <= a_mag;
                        rem             <= '0;
                        dvs             <= b_mag;
                        q_neg           <= a_neg ^ b_neg;
                        r_neg           <= a_neg;
                        l_rem           <= is_rem;
                        l_we            <= we_eff;
                        l_waddr         <= bus.id_ex_reg_reg_waddr_i;
                        cnt             <= '0;
                        bus.ex_reg_we_o <= 1'b0;
                        state           <= BUSY;
                    end else begin
                        bus.ex_reg_wdata_o <= is_div ? spec_res : alu_res;
                        bus.ex_reg_waddr_o <= bus.id_ex_reg_reg_waddr_i;
                        bus.ex_reg_we_o    <= we_eff;
                    end
                end
                BUSY: begin
                    if (!diff[XLEN]) begin
                        rem <= diff[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                    bus.ex_reg_we_o <= 1'b0;
                    cnt             <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= DONE;
                end
                DONE: begin
                    bus.ex_reg_wdata_o <= div_res;
                    bus.ex_reg_waddr_o <= l_waddr;
                    bus.ex_reg_we_o    <= l_we;
                    state              <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: table-driven single-cycle ops plus
// hand-written divide, back-to-back and mid-divide reset sequences.
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    ex_stage_if #(.XLEN(32)) bus ();
    ex_stage #(.XLEN(32), .DIV_CYCLES(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [4:0]  op;
        logic [31:0] a, b;
        logic [4:0]  wa;
        logic        we;
        logic [31:0] exp;
        logic        exp_we;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input string nm, input logic [4:0] op, input logic [31:0] a, b,
                           input logic [4:0] wa, input logic we, input logic [31:0] exp,
                           input logic exp_we);
        vec_t v;
        v.nm = nm; v.op = op; v.a = a; v.b = b; v.wa = wa; v.we = we;
        v.exp = exp; v.exp_we = exp_we;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, b,
                         input logic [4:0] wa, input logic we);
        bus.id_ex_reg_ALUctrl_i   = op;
        bus.id_ex_reg_op_a_i      = a;
        bus.id_ex_reg_op_b_i      = b;
        bus.id_ex_reg_reg_waddr_i = wa;
        bus.id_ex_reg_reg_we_i    = we;
    endtask

    // Drives a non-special divide, counts stall cycles, checks bubbles and the result.
    task automatic run_div(input string nm, input logic [4:0] op, input logic [31:0] a, b,
                           input logic [4:0] wa, input logic [31:0] exp);
        int cnt;
        bit bad;
        cnt = 0;
        bad = 0;
        @(negedge clk);
        drive(op, a, b, wa, 1'b1);
        #1;
        while (bus.ex_stall_o && cnt < 100) begin
            cnt++;
            @(posedge clk);
            #1;
            if (bus.ex_reg_we_o !== 1'b0) bad = 1;
        end
        chk({nm, "_stall_cycles"}, cnt, 33);
        chk({nm, "_bubble_we"}, {31'd0, bad}, 32'd0);
        @(posedge clk);
        #1;
        chk({nm, "_wdata"}, bus.ex_reg_wdata_o, exp);
        chk({nm, "_waddr"}, {27'd0, bus.ex_reg_waddr_o}, {27'd0, wa});
        chk({nm, "_we"}, {31'd0, bus.ex_reg_we_o}, 32'd1);
        drive(5'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        //       name        op     a             b             wa     we    exp           exp_we
        add_vec("add",      5'd1,  32'd3,        32'd4,        5'd5,  1'b1, 32'd7,        1'b1);
        add_vec("sub_wrap", 5'd2,  32'd0,        32'd1,        5'd1,  1'b1, 32'hFFFFFFFF, 1'b1);
        add_vec("and",      5'd3,  32'hF0F0,     32'hFF00,     5'd2,  1'b1, 32'hF000,     1'b1);
        add_vec("or",       5'd4,  32'hF0F0,     32'h0F0F,     5'd3,  1'b1, 32'hFFFF,     1'b1);
        add_vec("xor",      5'd5,  32'hFFFF,     32'h00FF,     5'd4,  1'b1, 32'hFF00,     1'b1);
        add_vec("sll_b40",  5'd6,  32'd1,        32'd35,       5'd6,  1'b1, 32'd8,        1'b1);
        add_vec("srl",      5'd7,  32'h80000000, 32'd4,        5'd7,  1'b1, 32'h08000000, 1'b1);
        add_vec("sra",      5'd8,  32'h80000000, 32'd4,        5'd8,  1'b1, 32'hF8000000, 1'b1);
        add_vec("slt",      5'd9,  32'hFFFFFFFF, 32'd1,        5'd9,  1'b1, 32'd1,        1'b1);
        add_vec("sltu",     5'd10, 32'hFFFFFFFF, 32'd1,        5'd10, 1'b1, 32'd0,        1'b1);
        add_vec("x0_dest",  5'd1,  32'd1,        32'd1,        5'd0,  1'b1, 32'd2,        1'b0);
        add_vec("no_op",    5'd0,  32'd5,        32'd5,        5'd11, 1'b1, 32'd0,        1'b0);
        add_vec("op_20",    5'd20, 32'd5,        32'd5,        5'd12, 1'b1, 32'd0,        1'b0);
        add_vec("we_off",   5'd1,  32'd3,        32'd4,        5'd13, 1'b0, 32'd7,        1'b0);
        add_vec("div_by0",  5'd11, 32'd5,        32'd0,        5'd14, 1'b1, 32'hFFFFFFFF, 1'b1);
        add_vec("remu_by0", 5'd14, 32'd5,        32'd0,        5'd15, 1'b1, 32'd5,        1'b1);
        add_vec("div_ovf",  5'd11, 32'h80000000, 32'hFFFFFFFF, 5'd16, 1'b1, 32'h80000000, 1'b1);
        add_vec("rem_ovf",  5'd13, 32'h80000000, 32'hFFFFFFFF, 5'd17, 1'b1, 32'd0,        1'b1);
        add_vec("divu_by0", 5'd12, 32'd9,        32'd0,        5'd18, 1'b1, 32'hFFFFFFFF, 1'b1);

        drive(5'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        #12;
        chk("reset_wdata", bus.ex_reg_wdata_o, 32'd0);
        chk("reset_waddr", {27'd0, bus.ex_reg_waddr_o}, 32'd0);
        chk("reset_we", {31'd0, bus.ex_reg_we_o}, 32'd0);
        chk("reset_stall", {31'd0, bus.ex_stall_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].wa, tbl[i].we);
            #1;
            chk({tbl[i].nm, "_stall"}, {31'd0, bus.ex_stall_o}, 32'd0);
            @(posedge clk);
            #1;
            chk({tbl[i].nm, "_wdata"}, bus.ex_reg_wdata_o, tbl[i].exp);
            chk({tbl[i].nm, "_waddr"}, {27'd0, bus.ex_reg_waddr_o}, {27'd0, tbl[i].wa});
            chk({tbl[i].nm, "_we"}, {31'd0, bus.ex_reg_we_o}, {31'd0, tbl[i].exp_we});
        end

        run_div("divu_100_7", 5'd12, 32'd100, 32'd7, 5'd3, 32'd14);
        run_div("remu_100_7", 5'd14, 32'd100, 32'd7, 5'd3, 32'd2);
        run_div("div_m7_2",   5'd11, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFD);
        run_div("rem_m7_2",   5'd13, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFF);
        run_div("rem_7_m2",   5'd13, 32'd7, 32'hFFFFFFFE, 5'd4, 32'd1);

        // Divide followed immediately by an ADD: exactly one writeback each, adjacent cycles.
        run_div("div_20_3", 5'd11, 32'd20, 32'd3, 5'd6, 32'd6);
        drive(5'd1, 32'd1, 32'd1, 5'd7, 1'b1);
        #1;
        chk("b2b_add_stall", {31'd0, bus.ex_stall_o}, 32'd0);
        @(posedge clk);
        #1;
        chk("b2b_add_wdata", bus.ex_reg_wdata_o, 32'd2);
        chk("b2b_add_waddr", {27'd0, bus.ex_reg_waddr_o}, 32'd7);
        chk("b2b_add_we", {31'd0, bus.ex_reg_we_o}, 32'd1);
        drive(5'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        chk("b2b_after_we", {31'd0, bus.ex_reg_we_o}, 32'd0);

        // Reset while the divider is ten steps in.
        @(negedge clk);
        drive(5'd12, 32'd100, 32'd7, 5'd3, 1'b1);
        repeat (11) @(posedge clk);
        #2;
        chk("midbusy_stall_pre", {31'd0, bus.ex_stall_o}, 32'd1);
        rst_n = 1'b0;
        drive(5'd1, 32'd3, 32'd4, 5'd5, 1'b1);
        #1;
        chk("midbusy_rst_wdata", bus.ex_reg_wdata_o, 32'd0);
        chk("midbusy_rst_waddr", {27'd0, bus.ex_reg_waddr_o}, 32'd0);
        chk("midbusy_rst_we", {31'd0, bus.ex_reg_we_o}, 32'd0);
        chk("midbusy_rst_stall", {31'd0, bus.ex_stall_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_add_wdata", bus.ex_reg_wdata_o, 32'd7);
        chk("post_rst_add_waddr", {27'd0, bus.ex_reg_waddr_o}, 32'd5);
        chk("post_rst_add_we", {31'd0, bus.ex_reg_we_o}, 32'd1);
        chk("post_rst_stall", {31'd0, bus.ex_stall_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage core, consuming the ID/EX pipeline register outputs: single-cycle ALU for integer ops plus an iterative radix-2 divider for DIV/DIVU/REM/REMU. Results go to the EX/MEM boundary through registered outputs. A stall output freezes the ID/EX register and all earlier stages while a division iterates.

## Interface
Parameters:
- `XLEN`, 32: operand and result width; only 32 is supported.
- `DIV_CYCLES`, 32: divider iterations; must equal `XLEN`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `id_ex_reg_op_a_i`  in  32  operand A (rs1 value).
- `id_ex_reg_op_b_i`  in  32  operand B (rs2 value or immediate).
- `id_ex_reg_ALUctrl_i`  in  5  operation code from the shared defines.
- `id_ex_reg_reg_waddr_i`  in  5  destination register.
- `id_ex_reg_reg_we_i`  in  1  writeback enable.
- `ex_reg_wdata_o`  out  32  registered result.
- `ex_reg_waddr_o`  out  5  registered destination.
- `ex_reg_we_o`  out  1  registered writeback enable.
- `ex_stall_o`  out  1  combinational stall; upstream holds ID/EX contents while high.

## Operation
- Opcodes: 0 `NO_OP`, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU, 11 DIV, 12 DIVU, 13 REM, 14 REMU. Codes 15-31 are treated as `NO_OP`: result 0 and `we` forced to 0.
- Shifts use `op_b[4:0]`. SLT and SLTU return 0 or 1, zero-extended. Add and subtract wrap modulo 2^32.
- `we_o` = `reg_we_i` AND (`waddr` != 0) AND (op != `NO_OP`).
- FSM states: IDLE, BUSY, DONE.
  - IDLE, non-divide op: result registered at the next edge; state stays IDLE.
  - IDLE, divide op, special case: result registered at the next edge with no stall; state stays IDLE.
    - Divisor 0: quotient 0xFFFFFFFF, remainder = dividend.
    - Signed DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - IDLE, divide op, otherwise: latch |A|, |B| (magnitudes for signed ops, raw values for unsigned), the sign flags, op, waddr and we. Go to BUSY with count = 0.
  - BUSY: one restoring-division step per cycle (shift remainder, trial subtract, set quotient bit); count increments. After the step with count = `DIV_CYCLES`-1, go to DONE.
  - DONE: apply sign fixup (quotient negated if operand signs differ; remainder takes the dividend's sign). Register the result with the latched waddr and we. Return to IDLE.
- `ex_stall_o` = 1 when (IDLE and non-special divide on inputs) or BUSY. It is 0 in DONE, so upstream advances on the same edge that EX captures the divide result.
- While stalled, outputs register a bubble: `we_o` = 0; `wdata_o` and `waddr_o` hold their values.
- Reset (any time, including mid-divide): state IDLE, count 0, `ex_reg_wdata_o` = 0, `ex_reg_waddr_o` = 0, `ex_reg_we_o` = 0. `ex_stall_o` then follows the inputs.

## Timing
- ALU ops and special-case divides: 1 cycle, inputs at cycle T appear on outputs after edge T+1.
- Normal divide presented at cycle T:
  - `ex_stall_o` high for cycles T..T+32 (33 cycles).
  - DONE at cycle T+33.
  - Result visible after edge T+34.
  - `we_o` = 0 after edges T+1..T+33.
- Back-to-back divides: the second divide sees IDLE at T+34 and starts a new sequence. No overlap.
- While the stall is high, input changes are illegal. The divider uses only latched values in BUSY and DONE.

## Test plan
- Reset mid-BUSY (count = 10): outputs go to 0 immediately; stall drops; the next ADD 3+4 to x5 gives wdata 7, waddr 5, we 1 one cycle later.
- ALU sweep: SUB 0 - 1 = 0xFFFFFFFF; SRA 0x80000000 >> 4 = 0xF8000000; SLT -1 < 1 = 1; SLTU 0xFFFFFFFF < 1 = 0; waddr 0 gives we 0.
- DIVU 100 / 7 to x3: stall high for exactly 33 cycles, `we_o` low throughout; then wdata 14, waddr 3, we 1. REMU on the same operands gives 2.
- Signed divides: DIV -7 / 2 = 0xFFFFFFFD (-3); REM -7 / 2 = 0xFFFFFFFF (-1); REM 7 / -2 = 1.
- Special cases with no stall, one-cycle result: DIV 5 / 0 = 0xFFFFFFFF; REMU 5 / 0 = 5; DIV 0x80000000 / -1 = 0x80000000; REM of the same = 0.
- DIV 20 / 3 immediately followed by ADD 1+1: ADD result appears one cycle after the divide result, with no lost or duplicated writeback.
